// File: rtl/fixed_point_alu.sv
// Multi-cycle Q(WIDTH-FBITS).FBITS ALU. ADD/SUB take one cycle, MUL uses a
// CHUNK x CHUNK slice multiplier, and SQRT uses a non-restoring digit recurrence.
module fixed_point_alu #(
  parameter int WIDTH = 32,
  parameter int FBITS = 10,
  parameter int CHUNK = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [2:0]       operation,
  input  logic             saturate,
  input  logic [WIDTH-1:0] operand_1,
  input  logic [WIDTH-1:0] operand_2,
  output logic [WIDTH-1:0] result,
  output logic             done,
  output logic             busy,
  output logic             overflow,
  output logic             illegal
);
  localparam int NS    = WIDTH / CHUNK;
  localparam int NMUL  = NS * NS;
  localparam int ITER  = (WIDTH + FBITS) / 2;
  localparam int MAXIT = (NMUL > ITER) ? NMUL : ITER;
  localparam int CW    = (MAXIT > 1) ? $clog2(MAXIT) : 1;
  localparam int SW    = (NS > 1) ? $clog2(NS) : 1;
  localparam int RW    = ITER + 2;
  localparam int PW    = 2 * WIDTH;

  typedef enum logic [2:0] {IDLE, ARITH, MUL, SQRT, FINISH} state_t;

  state_t            state_q;
  logic [WIDTH-1:0]  a_q, b_q, result_q;
  logic [2:0]        op_q;
  logic              sat_q, done_q, busy_q, ovf_q, ill_q;
  logic [CW-1:0]     cnt_q;
  logic [SW-1:0]     i_q, j_q;
  logic [PW-1:0]     acc_q;
  logic [2*ITER-1:0] rad_q;
  logic [RW-1:0]     rem_q;
  logic [ITER-1:0]   root_q;

  // ADD/SUB: subtraction folds into the adder by inverting operand 2.
  logic [WIDTH-1:0] b_eff, sum_d, sat_val;
  logic             as_ovf;
  assign b_eff   = op_q[0] ? ~b_q : b_q;
  assign sum_d   = a_q + b_eff + WIDTH'(op_q[0]);
  assign as_ovf  = (a_q[WIDTH-1] == b_eff[WIDTH-1]) && (sum_d[WIDTH-1] != a_q[WIDTH-1]);
  assign sat_val = {a_q[WIDTH-1], {(WIDTH-1){~a_q[WIDTH-1]}}};

  logic [CHUNK-1:0]   sa, sb;
  logic [2*CHUNK-1:0] pp;
  logic [PW-1:0]      acc_d;
  logic               mul_ovf;
  assign sa      = a_q[int'(i_q)*CHUNK +: CHUNK];
  assign sb      = b_q[int'(j_q)*CHUNK +: CHUNK];
  assign pp      = sa * sb;
  assign acc_d   = acc_q + (PW'(pp) << ((int'(i_q) + int'(j_q)) * CHUNK));
  assign mul_ovf = |acc_q[PW-1:WIDTH+FBITS];

  // Remainder stays signed; its sign picks subtract vs add for the next digit.
  logic [RW-1:0]   rem_sh, trial, rem_d;
  logic [ITER-1:0] root_d;
  assign rem_sh = {rem_q[RW-3:0], rad_q[2*ITER-1 -: 2]};
  assign trial  = rem_q[RW-1] ? {root_q, 2'b11} : {root_q, 2'b01};
  assign rem_d  = rem_q[RW-1] ? rem_sh + trial : rem_sh - trial;
  assign root_d = {root_q[ITER-2:0], ~rem_d[RW-1]};

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= IDLE;
      a_q      <= '0;
      b_q      <= '0;
      op_q     <= '0;
      sat_q    <= 1'b0;
      result_q <= '0;
      done_q   <= 1'b0;
      busy_q   <= 1'b0;
      ovf_q    <= 1'b0;
      ill_q    <= 1'b0;
      cnt_q    <= '0;
      i_q      <= '0;
      j_q      <= '0;
      acc_q    <= '0;
      rad_q    <= '0;
      rem_q    <= '0;
      root_q   <= '0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          busy_q <= 1'b0;
          if (start && !busy_q) begin
            busy_q <= 1'b1;
            a_q    <= operand_1;
            b_q    <= operand_2;
            op_q   <= operation;
            sat_q  <= saturate;
            cnt_q  <= '0;
            i_q    <= '0;
            j_q    <= '0;
            acc_q  <= '0;
            rem_q  <= '0;
            root_q <= '0;
            rad_q  <= {operand_1, {FBITS{1'b0}}};
            if (operation[2])       state_q <= FINISH;
            else if (!operation[1]) state_q <= ARITH;
            else if (!operation[0]) state_q <= MUL;
            else                    state_q <= SQRT;
          end
        end
        ARITH: begin
          result_q <= (as_ovf && sat_q) ? sat_val : sum_d;
          ovf_q    <= as_ovf;
          ill_q    <= 1'b0;
          done_q   <= 1'b1;
          state_q  <= IDLE;
        end
        MUL: begin
          acc_q <= acc_d;
          cnt_q <= cnt_q + CW'(1);
          if (j_q == SW'(NS - 1)) begin
            j_q <= '0;
            i_q <= i_q + SW'(1);
          end else begin
            j_q <= j_q + SW'(1);
          end
          if (cnt_q == CW'(NMUL - 1)) state_q <= FINISH;
        end
        SQRT: begin
          rem_q  <= rem_d;
          root_q <= root_d;
          rad_q  <= rad_q << 2;
          cnt_q  <= cnt_q + CW'(1);
          if (cnt_q == CW'(ITER - 1)) state_q <= FINISH;
        end
        FINISH: begin
          done_q  <= 1'b1;
          state_q <= IDLE;
          if (op_q[2]) begin
            result_q <= '0;
            ovf_q    <= 1'b0;
            ill_q    <= 1'b1;
          end else if (!op_q[0]) begin
            result_q <= (mul_ovf && sat_q) ? '1 : acc_q[WIDTH+FBITS-1:FBITS];
            ovf_q    <= mul_ovf;
            ill_q    <= 1'b0;
          end else begin
            result_q <= WIDTH'(root_q);
            ovf_q    <= 1'b0;
            ill_q    <= 1'b0;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign result   = result_q;
  assign done     = done_q;
  assign busy     = busy_q;
  assign overflow = ovf_q;
  assign illegal  = ill_q;
endmodule

// File: tb/tb_fixed_point_alu.sv
// Directed bench for fixed_point_alu: arithmetic reference model checked every
// cycle, plus literal expectations for the hand-computed vectors.
module tb_fixed_point_alu;
  localparam int W = 32, F = 10, C = 16;
  localparam int LAT_MUL = (W / C) * (W / C) + 1;
  localparam int LAT_SQRT = (W + F) / 2 + 1;

  logic         clk = 1'b0, reset = 1'b1, start = 1'b0, saturate = 1'b0;
  logic [2:0]   operation = 3'b000;
  logic [W-1:0] operand_1 = '0, operand_2 = '0;
  logic [W-1:0] result;
  logic         done, busy, overflow, illegal;

  fixed_point_alu #(.WIDTH(W), .FBITS(F), .CHUNK(C)) dut (
    .clk(clk), .reset(reset), .start(start), .operation(operation),
    .saturate(saturate), .operand_1(operand_1), .operand_2(operand_2),
    .result(result), .done(done), .busy(busy), .overflow(overflow), .illegal(illegal)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       nm;
    logic [31:0] res;
    bit          ovf;
    bit          ill;
    int          lat;
    int          e;
  } lit_t;

  lit_t        lit_q[$];
  int          tests = 0, fails = 0, cyc = 0;
  bit          act = 0;
  int          m_e = 0, m_l = 0;
  logic [31:0] m_res = '0, h_res = '0;
  bit          m_ovf = 0, m_ill = 0, h_ovf = 0, h_ill = 0;

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", nm, got, exp);
    end
  endtask

  // Reference model: plain wide arithmetic straight from the operation definitions.
  task automatic model(input logic [2:0] op, input bit sat, input logic [31:0] a, input logic [31:0] b);
    longint          sa, sb, r;
    longint unsigned p, x, t, q;
    m_ovf = 0; m_ill = 0; m_res = '0;
    if (op[2]) begin
      m_ill = 1; m_l = 1;
    end else if (op[1] == 1'b0) begin
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      r  = op[0] ? sa - sb : sa + sb;
      m_res = r[31:0];
      if (r > 64'sd2147483647)  begin m_ovf = 1; if (sat) m_res = 32'h7FFF_FFFF; end
      if (r < -64'sd2147483648) begin m_ovf = 1; if (sat) m_res = 32'h8000_0000; end
      m_l = 1;
    end else if (op[0] == 1'b0) begin
      p = 64'(a) * 64'(b);
      m_res = p[W+F-1:F];
      m_ovf = (p >> (W + F)) != 0;
      if (m_ovf && sat) m_res = '1;
      m_l = LAT_MUL;
    end else begin
      x = 64'(a) << F;
      q = 0;
      for (int k = 22; k >= 0; k--) begin
        t = q | (64'd1 << k);
        if (t * t <= x) q = t;
      end
      m_res = q[31:0];
      m_l = LAT_SQRT;
    end
  endtask

  task automatic issue(input logic [2:0] op, input bit sat, input logic [31:0] a, input logic [31:0] b,
                       input bit has_lit, input string nm, input logic [31:0] lres,
                       input bit lovf, input bit lill, input int llat);
    lit_t lt;
    @(negedge clk);
    start = 1'b1; operation = op; saturate = sat; operand_1 = a; operand_2 = b;
    model(op, sat, a, b);
    m_e = cyc + 1;
    act = 1;
    if (has_lit) begin
      lt.nm = nm; lt.res = lres; lt.ovf = lovf; lt.ill = lill; lt.lat = llat; lt.e = m_e;
      lit_q.push_back(lt);
    end
    @(negedge clk);
    start = 1'b0;
    operand_1 = $urandom; operand_2 = $urandom; saturate = 1'($urandom);
  endtask

  task automatic wait_done();
    for (int k = 0; k < 60 && !done; k++) @(negedge clk);
  endtask

  task automatic run(input logic [2:0] op, input bit sat, input logic [31:0] a, input logic [31:0] b,
                     input string nm, input logic [31:0] lres, input bit lovf, input bit lill, input int llat);
    issue(op, sat, a, b, 1, nm, lres, lovf, lill, llat);
    wait_done();
  endtask

  // Single compare process: async reset checks, per-cycle model checks, literal pins.
  always @(posedge clk or posedge reset) begin
    lit_t lt;
    bit   due, bsy;
    if (clk) cyc++;
    #1;
    if (reset) begin
      h_res = '0; h_ovf = 0; h_ill = 0;
      chk("rst_result", result, 32'h0);
      chk("rst_done", 32'(done), 32'h0);
      chk("rst_busy", 32'(busy), 32'h0);
      chk("rst_overflow", 32'(overflow), 32'h0);
      chk("rst_illegal", 32'(illegal), 32'h0);
    end else if (clk) begin
      due = act && (cyc == m_e + m_l);
      bsy = act && (cyc >= m_e) && (cyc <= m_e + m_l);
      if (due) begin h_res = m_res; h_ovf = m_ovf; h_ill = m_ill; end
      chk("done", 32'(done), 32'(due));
      chk("busy", 32'(busy), 32'(bsy));
      chk("result", result, h_res);
      chk("overflow", 32'(overflow), 32'(h_ovf));
      chk("illegal", 32'(illegal), 32'(h_ill));
      if (lit_q.size() > 0 && cyc >= lit_q[0].e + lit_q[0].lat) begin
        lt = lit_q.pop_front();
        chk({lt.nm, "_done"}, 32'(done), 32'h1);
        chk({lt.nm, "_result"}, result, lt.res);
        chk({lt.nm, "_ovf"}, 32'(overflow), 32'(lt.ovf));
        chk({lt.nm, "_ill"}, 32'(illegal), 32'(lt.ill));
      end
    end
  end

  initial begin
    repeat (3) @(negedge clk);
    reset = 1'b0;

    // Abort a SQRT five cycles in; no done may follow.
    issue(3'b011, 0, 32'd4096, 32'd0, 0, "", 32'h0, 0, 0, 0);
    while (cyc < m_e + 5) @(negedge clk);
    reset = 1'b1;
    act = 0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    repeat (30) @(negedge clk);

    run(3'b000, 0, 32'h400, 32'h800, "add_after_rst", 32'h0000_0C00, 0, 0, 1);
    run(3'b010, 0, 32'd1536, 32'd2304, "mul_1p5x2p25", 32'd3456, 0, 0, 5);
    run(3'b010, 1, 32'h0040_0000, 32'h0040_0000, "mul_ovf_sat", 32'hFFFF_FFFF, 1, 0, 5);
    run(3'b010, 0, 32'h0040_0000, 32'h0040_0000, "mul_ovf_wrap", 32'h0000_0000, 1, 0, 5);
    run(3'b010, 0, 32'h0001_2345, 32'h0003_0000, "mul_slices", 32'h00DA_73C0, 0, 0, 5);
    run(3'b000, 1, 32'h7FFF_FFFF, 32'h1, "add_sat_pos", 32'h7FFF_FFFF, 1, 0, 1);
    run(3'b000, 0, 32'h7FFF_FFFF, 32'h1, "add_wrap_pos", 32'h8000_0000, 1, 0, 1);
    run(3'b001, 1, 32'h8000_0000, 32'h1, "sub_sat_neg", 32'h8000_0000, 1, 0, 1);
    run(3'b001, 0, 32'h8000_0000, 32'h1, "sub_wrap_neg", 32'h7FFF_FFFF, 1, 0, 1);
    run(3'b011, 0, 32'd4096, 32'hDEAD_BEEF, "sqrt_4", 32'd2048, 0, 0, 22);
    run(3'b011, 0, 32'd0, 32'd5, "sqrt_0", 32'd0, 0, 0, 22);
    run(3'b011, 0, 32'd2048, 32'd0, "sqrt_2", 32'd1448, 0, 0, 22);
    issue(3'b011, 1, 32'hFFFF_FFFF, 32'd0, 0, "", 32'h0, 0, 0, 0);
    wait_done();

    // A second start while busy must not disturb the MUL in flight.
    issue(3'b010, 0, 32'h0000_0C00, 32'h0000_0A00, 1, "mul_ignore_start", 32'h0000_1E00, 0, 0, 5);
    @(negedge clk);
    start = 1'b1; operation = 3'b000; operand_1 = 32'h1111_1111; operand_2 = 32'h2222_2222;
    @(negedge clk);
    start = 1'b0;
    wait_done();

    run(3'b101, 1, 32'h1234_5678, 32'h9ABC_DEF0, "illegal_op", 32'h0, 0, 1, 1);
    run(3'b001, 0, 32'h400, 32'h800, "sub_clears_ill", 32'hFFFF_FC00, 0, 0, 1);
    repeat (4) @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
